// File: rtl/register_bank_io_pkg.sv
// Shared types and constants for the register_bank_io read/write bridge.
package register_bank_io_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    ACK  = 2'd2
  } state_t;

  localparam int DEF_ADDR_W     = 7;
  localparam int DEF_DATA_W     = 32;
  localparam int DEF_NUM_RO     = 44;
  localparam int DEF_NUM_LOCAL  = 8;
  localparam int DEF_LOCAL_BASE = 50;

  // Wide enough for any sane DATA_W; users slice off the low DATA_W bits.
  localparam int MAX_DATA_W = 1024;
  localparam logic [MAX_DATA_W-1:0] UNMAPPED_WORD = '1;

endpackage

// File: rtl/register_bank_io_local_setting_reg.sv
// local_setting_reg: one writable setting register, loaded when the settings
// write fires at its own address; synchronous active-low clear.
module local_setting_reg
  import register_bank_io_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int MATCH_ADDR = DEF_LOCAL_BASE
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] q
);

  localparam logic [ADDR_W-1:0] MATCH = ADDR_W'(MATCH_ADDR);

  always_ff @(posedge clk) begin
    if (!reset) begin
      q <= '0;
    end else if (wr_en && (wr_addr == MATCH)) begin
      q <= wr_data;
    end
  end

endmodule

// File: rtl/register_bank_io.sv
// Register read/write bridge: RO status bank + local settings bank, writes forwarded
// to the settings bus. Local readback enabled by `REGISTER_BANK_IO_READBACK_EN.
//   state | meaning
//   IDLE  | waiting for req; latches rd/addr/datain on acceptance
//   EXEC  | decode: register read data, or fire settings-bus write
//   ACK   | ack/err presented for one cycle, busy still high
module register_bank_io
  import register_bank_io_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int NUM_RO     = DEF_NUM_RO,
  parameter int NUM_LOCAL  = DEF_NUM_LOCAL,
  parameter int LOCAL_BASE = DEF_LOCAL_BASE
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        req,
  input  logic                        rd,
  input  logic [ADDR_W-1:0]           addr,
  input  logic [DATA_W-1:0]           datain,
  output logic                        ack,
  output logic [DATA_W-1:0]           dataout,
  output logic                        err,
  output logic                        busy,
  input  logic [NUM_RO*DATA_W-1:0]    ro_bus,
  output logic [ADDR_W-1:0]           addr_wr,
  output logic [DATA_W-1:0]           data_wr,
  output logic                        strobe_wr,
  output logic [NUM_LOCAL*DATA_W-1:0] local_out
);

  state_t state, state_nxt;

  logic                        lat_rd;
  logic [ADDR_W-1:0]           lat_addr;
  logic [DATA_W-1:0]           lat_data;
  logic                        accept;
  logic                        exec_rd;
  logic                        exec_wr;
  logic                        in_local;
  logic [31:0]                 addr_ext;
  logic [DATA_W-1:0]           rd_word;
  logic [NUM_LOCAL*DATA_W-1:0] local_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    exec_rd   = 1'b0;
    exec_wr   = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          accept    = 1'b1;
          state_nxt = EXEC;
        end
      end
      EXEC: begin
        exec_rd   = lat_rd;
        exec_wr   = !lat_rd;
        state_nxt = ACK;
      end
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!reset) begin
      lat_rd   <= 1'b0;
      lat_addr <= '0;
      lat_data <= '0;
    end else if (accept) begin
      lat_rd   <= rd;
      lat_addr <= addr;
      lat_data <= datain;
    end
  end

  assign addr_ext = 32'(lat_addr);
  assign in_local = (addr_ext >= 32'(LOCAL_BASE)) &&
                    (addr_ext <  32'(LOCAL_BASE + NUM_LOCAL));

  // Later matches override earlier ones, so the local bank wins over RO on overlap.
  always_comb begin
    rd_word = UNMAPPED_WORD[DATA_W-1:0];
    for (int k = 0; k < NUM_RO; k++) begin
      if (addr_ext == 32'(k)) begin
        rd_word = ro_bus[k*DATA_W +: DATA_W];
      end
    end
`ifdef REGISTER_BANK_IO_READBACK_EN
    for (int j = 0; j < NUM_LOCAL; j++) begin
      if (addr_ext == 32'(LOCAL_BASE + j)) begin
        rd_word = local_q[j*DATA_W +: DATA_W];
      end
    end
`endif
  end

  // Writes into the local range (overlap included) are legal; everything else is flagged.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ack       <= 1'b0;
      err       <= 1'b0;
      dataout   <= '0;
      strobe_wr <= 1'b0;
      addr_wr   <= '0;
      data_wr   <= '0;
    end else begin
      ack       <= (state == EXEC);
      err       <= exec_wr && !in_local;
      strobe_wr <= exec_wr;
      if (exec_rd) begin
        dataout <= rd_word;
      end
      if (exec_wr) begin
        addr_wr <= lat_addr;
        data_wr <= lat_data;
      end
    end
  end

  for (genvar i = 0; i < NUM_LOCAL; i++) begin : g_local
    local_setting_reg #(
      .ADDR_W     (ADDR_W),
      .DATA_W     (DATA_W),
      .MATCH_ADDR (LOCAL_BASE + i)
    ) u_reg (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (exec_wr),
      .wr_addr (lat_addr),
      .wr_data (lat_data),
      .q       (local_q[i*DATA_W +: DATA_W])
    );
  end

  assign local_out = local_q;

endmodule

// File: tb/tb_register_bank_io.sv
// Directed self-checking bench for register_bank_io (honours `REGISTER_BANK_IO_READBACK_EN).
module tb_register_bank_io;

  localparam int ADDR_W     = 7;
  localparam int DATA_W     = 32;
  localparam int NUM_RO     = 44;
  localparam int NUM_LOCAL  = 8;
  localparam int LOCAL_BASE = 50;

  logic                        clk = 1'b0;
  logic                        reset;
  logic                        req;
  logic                        rd;
  logic [ADDR_W-1:0]           addr;
  logic [DATA_W-1:0]           datain;
  logic                        ack;
  logic [DATA_W-1:0]           dataout;
  logic                        err;
  logic                        busy;
  logic [NUM_RO*DATA_W-1:0]    ro_bus;
  logic [ADDR_W-1:0]           addr_wr;
  logic [DATA_W-1:0]           data_wr;
  logic                        strobe_wr;
  logic [NUM_LOCAL*DATA_W-1:0] local_out;

  int n_tests = 0;
  int n_fail  = 0;
  logic [DATA_W-1:0] exp_local [NUM_LOCAL];
  logic [NUM_LOCAL*DATA_W-1:0] exp_vec;

  register_bank_io #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_RO(NUM_RO),
    .NUM_LOCAL(NUM_LOCAL), .LOCAL_BASE(LOCAL_BASE)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .rd(rd), .addr(addr), .datain(datain),
    .ack(ack), .dataout(dataout), .err(err), .busy(busy), .ro_bus(ro_bus),
    .addr_wr(addr_wr), .data_wr(data_wr), .strobe_wr(strobe_wr), .local_out(local_out)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [NUM_LOCAL*DATA_W-1:0] pack_local();
    logic [NUM_LOCAL*DATA_W-1:0] v;
    for (int i = 0; i < NUM_LOCAL; i++) v[i*DATA_W +: DATA_W] = exp_local[i];
    return v;
  endfunction

  // Called at a negedge in IDLE; returns at the negedge of the EXEC cycle.
  task automatic pulse_req(input logic r, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    req = 1'b1; rd = r; addr = a; datain = d;
    @(negedge clk);
    req = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; req = 1'b0; rd = 1'b0; addr = '0; datain = '0;
    for (int i = 0; i < NUM_LOCAL; i++) exp_local[i] = '0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_tests++;
      if ({ack, err, busy, strobe_wr} !== 4'b0000 || dataout !== '0 || addr_wr !== '0 ||
          data_wr !== '0 || local_out !== '0) begin
        n_fail++;
        $display("FAIL reset_outputs cyc%0d: ack=%b err=%b busy=%b strobe=%b dataout=%h addr_wr=%h data_wr=%h local_out!=0:%b, required all 0",
                 c, ack, err, busy, strobe_wr, dataout, addr_wr, data_wr, local_out !== '0);
      end
      req = ~req; rd = 1'b0; addr = 7'd51; datain = 32'h1111_1111;
    end
    req = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    n_tests++;
    if (busy !== 1'b0 || ack !== 1'b0) begin
      n_fail++; $display("FAIL reset_release: busy=%b ack=%b, required 0 0", busy, ack);
    end
  endtask

  task automatic test_ro_read();
    for (int k = 0; k < NUM_RO; k++) ro_bus[k*DATA_W +: DATA_W] = 32'h0101_0101 * k;
    ro_bus[0*DATA_W +: DATA_W] = 32'h0BAD_F00D;
    ro_bus[2*DATA_W +: DATA_W] = 32'h0000_0ABC;
    pulse_req(1'b1, 7'd2, 32'h0);
    n_tests++;
    if (busy !== 1'b1 || ack !== 1'b0 || strobe_wr !== 1'b0) begin
      n_fail++; $display("FAIL ro_read_exec: busy=%b ack=%b strobe=%b, required 1 0 0", busy, ack, strobe_wr);
    end
    @(negedge clk);
    n_tests++;
    if (ack !== 1'b1 || dataout !== 32'h0000_0ABC || err !== 1'b0 || strobe_wr !== 1'b0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL ro_read_ack: ack=%b dataout=%h err=%b strobe=%b busy=%b, required 1 00000abc 0 0 1",
                         ack, dataout, err, strobe_wr, busy);
    end
    @(negedge clk);
    n_tests++;
    if (ack !== 1'b0 || busy !== 1'b0 || strobe_wr !== 1'b0 || dataout !== 32'h0000_0ABC) begin
      n_fail++; $display("FAIL ro_read_idle: ack=%b busy=%b strobe=%b dataout=%h, required 0 0 0 00000abc",
                         ack, busy, strobe_wr, dataout);
    end
    pulse_req(1'b1, 7'd43, 32'h0);
    @(negedge clk);
    n_tests++;
    if (ack !== 1'b1 || dataout !== 32'h2B2B_2B2B || err !== 1'b0) begin
      n_fail++; $display("FAIL ro_read_last: ack=%b dataout=%h err=%b, required 1 2b2b2b2b 0", ack, dataout, err);
    end
    @(negedge clk);
    pulse_req(1'b1, 7'd44, 32'h0);
    @(negedge clk);
    n_tests++;
    if (ack !== 1'b1 || dataout !== 32'hFFFF_FFFF || err !== 1'b0) begin
      n_fail++; $display("FAIL ro_read_past_end: ack=%b dataout=%h err=%b, required 1 ffffffff 0", ack, dataout, err);
    end
    @(negedge clk);
  endtask

  task automatic test_local_write();
    logic [DATA_W-1:0] exp_rb;
    pulse_req(1'b0, 7'd51, 32'hDEAD_BEEF);
    n_tests++;
    if (strobe_wr !== 1'b0 || local_out !== pack_local()) begin
      n_fail++; $display("FAIL local_wr_exec: strobe=%b local_out=%h, required strobe 0 locals unchanged", strobe_wr, local_out);
    end
    @(negedge clk);
    exp_local[1] = 32'hDEAD_BEEF;
    exp_vec = pack_local();
    n_tests++;
    if (ack !== 1'b1 || err !== 1'b0 || strobe_wr !== 1'b1 || addr_wr !== 7'd51 ||
        data_wr !== 32'hDEAD_BEEF || local_out !== exp_vec) begin
      n_fail++; $display("FAIL local_wr_ack: ack=%b err=%b strobe=%b addr_wr=%0d data_wr=%h local_out=%h, required 1 0 1 51 deadbeef %h",
                         ack, err, strobe_wr, addr_wr, data_wr, local_out, exp_vec);
    end
    @(negedge clk);
    n_tests++;
    if (strobe_wr !== 1'b0 || ack !== 1'b0) begin
      n_fail++; $display("FAIL local_wr_strobe_len: strobe=%b ack=%b, required 0 0", strobe_wr, ack);
    end
`ifdef REGISTER_BANK_IO_READBACK_EN
    exp_rb = 32'hDEAD_BEEF;
`else
    exp_rb = 32'hFFFF_FFFF;
`endif
    pulse_req(1'b1, 7'd51, 32'h0);
    @(negedge clk);
    n_tests++;
    if (ack !== 1'b1 || dataout !== exp_rb || err !== 1'b0 || strobe_wr !== 1'b0) begin
      n_fail++; $display("FAIL local_readback: ack=%b dataout=%h err=%b strobe=%b, required 1 %h 0 0",
                         ack, dataout, err, strobe_wr, exp_rb);
    end
    @(negedge clk);
    pulse_req(1'b0, 7'd57, 32'h1234_5678);
    @(negedge clk);
    exp_local[7] = 32'h1234_5678;
    exp_vec = pack_local();
    n_tests++;
    if (ack !== 1'b1 || err !== 1'b0 || local_out !== exp_vec) begin
      n_fail++; $display("FAIL local_wr_top: ack=%b err=%b local_out=%h, required 1 0 %h", ack, err, local_out, exp_vec);
    end
    @(negedge clk);
    pulse_req(1'b0, 7'd58, 32'h0000_0005);
    @(negedge clk);
    n_tests++;
    if (ack !== 1'b1 || err !== 1'b1 || strobe_wr !== 1'b1 || addr_wr !== 7'd58 || local_out !== exp_vec) begin
      n_fail++; $display("FAIL local_wr_past_end: ack=%b err=%b strobe=%b addr_wr=%0d local_out=%h, required 1 1 1 58 %h",
                         ack, err, strobe_wr, addr_wr, local_out, exp_vec);
    end
    @(negedge clk);
  endtask

  task automatic test_unmapped();
    pulse_req(1'b1, 7'd45, 32'h0);
    @(negedge clk);
    n_tests++;
    if (ack !== 1'b1 || dataout !== 32'hFFFF_FFFF || err !== 1'b0) begin
      n_fail++; $display("FAIL unmapped_read45: ack=%b dataout=%h err=%b, required 1 ffffffff 0", ack, dataout, err);
    end
    @(negedge clk);
    pulse_req(1'b0, 7'd3, 32'hA5A5_A5A5);
    @(negedge clk);
    exp_vec = pack_local();
    n_tests++;
    if (ack !== 1'b1 || err !== 1'b1 || strobe_wr !== 1'b1 || addr_wr !== 7'd3 ||
        data_wr !== 32'hA5A5_A5A5 || local_out !== exp_vec) begin
      n_fail++; $display("FAIL ro_write3: ack=%b err=%b strobe=%b addr_wr=%0d data_wr=%h local_out=%h, required 1 1 1 3 a5a5a5a5 %h",
                         ack, err, strobe_wr, addr_wr, data_wr, local_out, exp_vec);
    end
    @(negedge clk);
    pulse_req(1'b0, 7'd100, 32'h0000_0064);
    @(negedge clk);
    n_tests++;
    if (ack !== 1'b1 || err !== 1'b1 || strobe_wr !== 1'b1 || addr_wr !== 7'd100 || local_out !== exp_vec) begin
      n_fail++; $display("FAIL write100: ack=%b err=%b strobe=%b addr_wr=%0d local_out=%h, required 1 1 1 100 %h",
                         ack, err, strobe_wr, addr_wr, local_out, exp_vec);
    end
    @(negedge clk);
  endtask

  task automatic test_busy_drop();
    int n_ack = 0;
    int n_strobe = 0;
    req = 1'b1; rd = 1'b1; addr = 7'd0; datain = '0;
    @(negedge clk);
    req = 1'b1; rd = 1'b0; addr = 7'd50; datain = 32'h0000_0001;
    @(negedge clk);
    req = 1'b0;
    for (int c = 0; c < 5; c++) begin
      if (ack === 1'b1) n_ack++;
      if (strobe_wr === 1'b1) n_strobe++;
      @(negedge clk);
    end
    exp_vec = pack_local();
    n_tests++;
    if (n_ack != 1 || n_strobe != 0 || dataout !== 32'h0BAD_F00D || local_out !== exp_vec || busy !== 1'b0) begin
      n_fail++; $display("FAIL busy_drop: acks=%0d strobes=%0d dataout=%h local_out=%h busy=%b, required 1 0 0badf00d %h 0",
                         n_ack, n_strobe, dataout, local_out, exp_vec, busy);
    end
  endtask

  task automatic test_mid_reset();
    logic [DATA_W-1:0] exp_rb;
    pulse_req(1'b0, 7'd52, 32'hCAFE_0001);
    reset = 1'b0;
    @(negedge clk);
    for (int i = 0; i < NUM_LOCAL; i++) exp_local[i] = '0;
    n_tests++;
    if (ack !== 1'b0 || strobe_wr !== 1'b0 || busy !== 1'b0 || dataout !== '0 || local_out !== '0) begin
      n_fail++; $display("FAIL mid_reset: ack=%b strobe=%b busy=%b dataout=%h local_out=%h, required all 0",
                         ack, strobe_wr, busy, dataout, local_out);
    end
    reset = 1'b1;
    @(negedge clk);
    n_tests++;
    if (ack !== 1'b0 || busy !== 1'b0 || local_out !== '0) begin
      n_fail++; $display("FAIL mid_reset_release: ack=%b busy=%b local_out=%h, required 0 0 0", ack, busy, local_out);
    end
    pulse_req(1'b0, 7'd52, 32'h5252_5252);
    @(negedge clk);
    exp_local[2] = 32'h5252_5252;
    exp_vec = pack_local();
    n_tests++;
    if (ack !== 1'b1 || err !== 1'b0 || strobe_wr !== 1'b1 || local_out !== exp_vec) begin
      n_fail++; $display("FAIL post_reset_write: ack=%b err=%b strobe=%b local_out=%h, required 1 0 1 %h",
                         ack, err, strobe_wr, local_out, exp_vec);
    end
    @(negedge clk);
`ifdef REGISTER_BANK_IO_READBACK_EN
    exp_rb = 32'h5252_5252;
`else
    exp_rb = 32'hFFFF_FFFF;
`endif
    pulse_req(1'b1, 7'd52, 32'h0);
    @(negedge clk);
    n_tests++;
    if (ack !== 1'b1 || dataout !== exp_rb || err !== 1'b0) begin
      n_fail++; $display("FAIL post_reset_read: ack=%b dataout=%h err=%b, required 1 %h 0", ack, dataout, err, exp_rb);
    end
    @(negedge clk);
  endtask

  initial begin
    ro_bus = '0;
    test_reset();
    test_ro_read();
    test_local_write();
    test_unmapped();
    test_busy_drop();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/register_bank_io.md
# register_bank_io

Parametrised register read/write bridge between the inband command decoder and the FPGA control/status registers. It accepts single-word read or write requests over a pulse/ack handshake. Reads return a flattened bank of external read-only status words plus an internal bank of writable setting registers. Writes are forwarded as a registered one-cycle `strobe_wr`/`addr_wr`/`data_wr` triple onto the common settings bus.

## Interface
- `ADDR_W`, 7, request/settings address width
- `DATA_W`, 32, data word width
- `NUM_RO`, 44, number of external read-only words, mapped at addresses 0..NUM_RO-1
- `NUM_LOCAL`, 8, number of internal setting registers
- `LOCAL_BASE`, 50, first address of the internal setting registers
- `clk`  in  1  system clock
- `reset`  in  1  synchronous reset, active-low
- `req`  in  1  one-cycle request pulse, honoured only when `busy`=0
- `rd`  in  1  request type, sampled with `req`: 1=read, 0=write
- `addr`  in  ADDR_W  request address, sampled with `req`
- `datain`  in  DATA_W  write data, sampled with `req`
- `ack`  out  1  one-cycle completion pulse
- `dataout`  out  DATA_W  read data, valid while `ack`=1, held until the next read completes
- `err`  out  1  valid with `ack`; set on a write to the RO range or a write outside every mapped range
- `busy`  out  1  request in flight
- `ro_bus`  in  NUM_RO*DATA_W  flattened status words; word k sits at bits [k*DATA_W +: DATA_W]
- `addr_wr`  out  ADDR_W  settings-bus address
- `data_wr`  out  DATA_W  settings-bus data
- `strobe_wr`  out  1  settings-bus write strobe
- `local_out`  out  NUM_LOCAL*DATA_W  flattened internal setting register values

## Operation
- FSM states: IDLE, EXEC, ACK.
- IDLE: on `req`=1, latch `rd`, `addr` and `datain`, then go to EXEC.
- EXEC, read: address decode with priority local > RO > unmapped.
  - Local range: the local register value.
  - RO range: the `ro_bus` word.
  - Anything else: all ones.
  - The result is registered into `dataout`. Go to ACK.
- EXEC, write:
  - Drive `strobe_wr`=1 for exactly one cycle, with `addr_wr`/`data_wr` set to the latched values. Every write is forwarded, regardless of address.
  - If the address is in the local range, the matching local register loads `data_wr` on the same edge.
  - Go to ACK.
- ACK: `ack`=1 for one cycle, then return to IDLE. `err`=1 only for writes with address < NUM_RO, or with address outside both the RO and local ranges. Reads never flag `err`.
- `req` while `busy`=1: ignored and dropped, with no queueing.
- Overlapping ranges: the local range wins for reads. A write into an overlap is not flagged as an error.
- Reset (`reset`=0 at a clock edge) returns the FSM to IDLE and clears every output to 0: `ack`, `err`, `busy`, `strobe_wr`, `addr_wr`, `data_wr`, `dataout`, and all local registers.
- Reset mid-transaction aborts it: no `ack` is issued and no local register is written afterwards.

## Timing
- Request accepted at edge 0.
- Edge 1: EXEC. Read data is registered, or `strobe_wr`/`addr_wr`/`data_wr` are registered.
- Edge 2: `ack` is high during the cycle following EXEC.
- Latency from `req` to `ack`: 2 cycles.
- Throughput: one request per 3 cycles. A new `req` is accepted in the cycle after `ack`.
- `busy` is high from the cycle after `req` through the `ack` cycle inclusive.
- `strobe_wr` is high in the EXEC-following cycle only, and is never asserted for reads.
- A local register is visible on `local_out` in the same cycle that `strobe_wr` is high.
- A readback issued immediately after a write returns the new value.

## Configuration
- `REGISTER_BANK_IO_READBACK_EN` defined: local registers are readable at LOCAL_BASE.. as described above.
- Macro undefined:
  - Reads of the local range fall through to RO/unmapped decode, normally all ones.
  - Local registers remain writable and drive `local_out`.
  - A write to the local range still sets `err`=0.

## Structure
- Shared package `register_bank_io_pkg`:
  - FSM state enum (IDLE/EXEC/ACK).
  - Constant `UNMAPPED_WORD` (all ones).
  - Default parameter constants.
- Sub-module `local_setting_reg`: one writable register with address match against its instance parameter, synchronous active-low clear, and strobe-qualified load. Instantiated NUM_LOCAL times from a generate loop.

## Test plan
- Reset then idle:
  - Hold `reset`=0 for 3 cycles with `req` toggling: all outputs stay 0 and no `ack` is issued.
  - Release reset: `busy`=0.
- RO read:
  - Stimulus: `ro_bus` word 2 = 0x00000ABC; `req`, `rd`=1, `addr`=2 at edge 0.
  - Response: `ack` at edge 2, `dataout`=0x00000ABC, `err`=0, `strobe_wr` never high.
- Local write plus readback:
  - Write 0xDEADBEEF to address 51: `strobe_wr` for one cycle with `addr_wr`=51, `ack` with `err`=0, `local_out` word 1 = 0xDEADBEEF.
  - Read 51: `dataout`=0xDEADBEEF with the macro defined; 0xFFFFFFFF without it.
- Unmapped and illegal accesses:
  - Read address 45: `dataout`=0xFFFFFFFF, `err`=0.
  - Write address 3: `strobe_wr` pulses, `err`=1, no local register changes.
  - Write address 100: `err`=1.
- Busy drop: a second `req` pulse (write 0x1 to address 50) one cycle after the first (read address 0) is ignored. Exactly one `ack` is issued and `local_out` word 0 stays 0.
- Mid-operation reset: assert `reset`=0 in the EXEC cycle of a write to address 52. No `ack`, `local_out` word 2 = 0, FSM in IDLE, and a new request after release completes normally.
